alu_power_scheduler: RTL and testbench
======================================

ALU_POWER_SCHEDULER -- requirements
Module: alu_power_scheduler

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing one 4-bit ALU (2..4).
REQ-002 Parameter IDLE_TIMEOUT, default 8: idle cycles in ON before power-down starts.
REQ-003 Parameter WAKE_CYCLES, default 3: cycles in WAKE before RESTORE.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-high.
REQ-006 req_valid  in  N_REQ  per-requester operation request.
REQ-007 req_a, req_b  in  4*N_REQ each  packed operands; requester i uses bits [4i+3:4i].
REQ-008 req_op  in  3*N_REQ  packed 3-bit ALU opcodes.
REQ-009 req_ready  out  N_REQ  one-hot grant; transfer when req_valid[i] & req_ready[i].
REQ-010 alu_a, alu_b  out  4 each; alu_op  out  3  registered operands to the external ALU.
REQ-011 alu_result  in  4  combinational ALU result for alu_a/alu_b/alu_op.
REQ-012 rsp_valid  out  1; rsp_id  out  2; rsp_result  out  4  one-cycle response pulse.
REQ-013 pwr_en, iso_en, save, restore  out  1 each  ALU power-domain controls.
REQ-014 pwr_state  out  3  current FSM state encoding.

Function
REQ-015 FSM states: ON, ISO, OFF, WAKE, RESTORE; pwr_state encodes ON=0, ISO=1, OFF=2, WAKE=3, RESTORE=4.
REQ-016 pwr_en=1 in ON, ISO, WAKE, RESTORE; pwr_en=0 in OFF.
REQ-017 iso_en=1 in ISO, OFF, WAKE, RESTORE; iso_en=0 in ON.
REQ-018 save=1 only in ISO, restore=1 only in RESTORE; each lasts exactly one cycle.
REQ-019 req_ready is nonzero only in ON; at most one bit set, to the highest-priority requester with req_valid=1.
REQ-020 Round-robin priority; after a grant to i, requester (i+1) mod N_REQ becomes highest priority; pointer unchanged on cycles with no grant.
REQ-021 On a transfer at edge T, alu_a/alu_b/alu_op load the granted operands; at edge T+1 rsp_result<=alu_result, rsp_id<=granted index, rsp_valid=1 for one cycle.
REQ-022 Throughput: one transfer per cycle in ON; back-to-back responses allowed.
REQ-023 Idle counter: in ON, counts when req_valid==0 and no op is in flight; cleared by any req_valid bit or in-flight op; saturates at IDLE_TIMEOUT.
REQ-024 ON->ISO at the edge where the idle counter equals IDLE_TIMEOUT and req_valid==0; ISO never entered with an op in flight.
REQ-025 ISO->OFF unconditionally after one cycle, even if req_valid rises during ISO.
REQ-026 OFF->WAKE on the edge where any req_valid bit is 1; otherwise remain OFF.
REQ-027 WAKE lasts exactly WAKE_CYCLES cycles, then RESTORE (one cycle), then ON.
REQ-028 In ON, req_valid==1 on the cycle the counter reaches IDLE_TIMEOUT: grant takes priority, stay ON, counter cleared.
REQ-029 alu_a/alu_b/alu_op hold their last values outside ON; rsp_valid=0 outside response cycles.

Reset
REQ-030 Reset forces: state ON, pwr_en=1, iso_en=0, save=0, restore=0, req_ready=0 during reset, rsp_valid=0, rsp_id=0, rsp_result=0, alu_a/alu_b/alu_op=0, RR pointer=0, idle and wake counters=0.
REQ-031 Reset asserted mid-sequence (ISO/OFF/WAKE/RESTORE) returns to ON immediately; in-flight op discarded, no rsp_valid.

Structure
REQ-032 Shared package holds the FSM state enumeration, ALU opcode constants, and default parameter values.
REQ-033 One sub-module, rr_arbiter (N_REQ requests, enable, one-hot grant, priority pointer), instantiated once.

Verification
REQ-034 Reset, then req 0 valid A=3,B=4,op=000 -> ready[0] at cycle 1, rsp_valid with rsp_id=0, rsp_result=7 one cycle after transfer.
REQ-035 All 4 requesters valid continuously -> grants in order 0,1,2,3,0, one per cycle, rsp_ids match.
REQ-036 No requests for 8 cycles after last response -> ISO (save=1, 1 cycle), then OFF with pwr_en=0, iso_en=1.
REQ-037 In OFF, req 2 valid A=9,B=1,op=001 -> WAKE 3 cycles, RESTORE pulse, ON, then rsp_id=2, rsp_result=8.
REQ-038 req_valid raised during ISO -> OFF for one cycle, then WAKE; request served after RESTORE.
REQ-039 Reset pulsed during WAKE -> state ON, pwr_en=1, iso_en=0 while reset high, no stray rsp_valid.

Source files
------------

// File: rtl/alu_power_scheduler_pkg.sv
// Shared types, opcodes and default parameters for the ALU power scheduler.
package alu_power_scheduler_pkg;

   localparam int DEF_N_REQ        = 4;
   localparam int DEF_IDLE_TIMEOUT = 8;
   localparam int DEF_WAKE_CYCLES  = 3;

   typedef enum logic [2:0] {
      PS_ON      = 3'd0,
      PS_ISO     = 3'd1,
      PS_OFF     = 3'd2,
      PS_WAKE    = 3'd3,
      PS_RESTORE = 3'd4
   } pwr_state_e;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_NOT = 3'b101;
   localparam logic [2:0] OP_SHL = 3'b110;
   localparam logic [2:0] OP_SHR = 3'b111;

   typedef struct packed {
      logic [3:0] a;
      logic [3:0] b;
      logic [2:0] op;
   } alu_cmd_t;

   // Round-robin successor of a granted index among n requesters.
   function automatic logic [1:0] rr_next(input logic [1:0] idx, input int n);
      return (int'(idx) == n - 1) ? 2'd0 : idx + 2'd1;
   endfunction

endpackage

// File: rtl/alu_power_scheduler_if.sv
// Request, external-ALU and response signals of the ALU power scheduler.
interface alu_power_scheduler_if
   import alu_power_scheduler_pkg::*;
#(
   parameter int N_REQ = DEF_N_REQ
) ();

   logic [N_REQ-1:0]   req_valid;
   logic [4*N_REQ-1:0] req_a;
   logic [4*N_REQ-1:0] req_b;
   logic [3*N_REQ-1:0] req_op;
   logic [N_REQ-1:0]   req_ready;
   logic [3:0]         alu_a;
   logic [3:0]         alu_b;
   logic [2:0]         alu_op;
   logic [3:0]         alu_result;
   logic               rsp_valid;
   logic [1:0]         rsp_id;
   logic [3:0]         rsp_result;

   modport master (
      output req_valid, req_a, req_b, req_op, alu_result,
      input  req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_id, rsp_result
   );

   modport slave (
      input  req_valid, req_a, req_b, req_op, alu_result,
      output req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_id, rsp_result
   );

endinterface

// File: rtl/alu_power_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting the search at the priority pointer.
module rr_arbiter
   import alu_power_scheduler_pkg::*;
#(
   parameter int N_REQ = DEF_N_REQ
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] grant,
   output logic [1:0]       grant_idx,
   output logic             grant_valid
);

   logic [1:0] ptr_reg;
   logic [2:0] cand;

   always_comb begin
      grant       = '0;
      grant_idx   = '0;
      grant_valid = 1'b0;
      cand        = '0;
      for (int k = 0; k < N_REQ; k++) begin
         cand = {1'b0, ptr_reg} + 3'(k);
         if (cand >= 3'(N_REQ)) begin
            cand = cand - 3'(N_REQ);
         end
         if (en && !grant_valid && req[cand[1:0]]) begin
            grant[cand[1:0]] = 1'b1;
            grant_idx        = cand[1:0];
            grant_valid      = 1'b1;
         end
      end
   end

   // Pointer only moves on a grant, so idle cycles keep the current priority.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr_reg <= '0;
      end else if (grant_valid) begin
         ptr_reg <= rr_next(grant_idx, N_REQ);
      end
   end

endmodule

// File: rtl/alu_power_scheduler.sv
// Shares one 4-bit ALU among requesters and power-gates it after an idle timeout.
module alu_power_scheduler
   import alu_power_scheduler_pkg::*;
#(
   parameter int N_REQ        = DEF_N_REQ,
   parameter int IDLE_TIMEOUT = DEF_IDLE_TIMEOUT,
   parameter int WAKE_CYCLES  = DEF_WAKE_CYCLES
) (
   input  logic                  clk,
   input  logic                  reset,
   alu_power_scheduler_if.slave  bus,
   output logic                  pwr_en,
   output logic                  iso_en,
   output logic                  save,
   output logic                  restore,
   output logic [2:0]            pwr_state
);

   localparam logic [2:0] ST_ON      = PS_ON;
   localparam logic [2:0] ST_ISO     = PS_ISO;
   localparam logic [2:0] ST_OFF     = PS_OFF;
   localparam logic [2:0] ST_WAKE    = PS_WAKE;
   localparam logic [2:0] ST_RESTORE = PS_RESTORE;

   localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);
   localparam int WAKE_W = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;

   logic [2:0]        state_reg, state_next;
   logic [IDLE_W-1:0] idle_reg;
   logic [WAKE_W-1:0] wake_reg;
   logic              inflight_reg;
   logic [1:0]        inflight_id_reg;
   alu_cmd_t          cmd_reg;
   logic              rsp_valid_reg;
   logic [1:0]        rsp_id_reg;
   logic [3:0]        rsp_result_reg;

   alu_cmd_t          req_cmd [N_REQ];
   logic [N_REQ-1:0]  grant;
   logic [1:0]        grant_idx;
   logic              grant_valid;
   logic              arb_en;
   logic              any_valid;
   logic              idle_expired;
   logic              wake_done;

   genvar gi;
   generate
      for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
         assign req_cmd[gi] = {bus.req_a[4*gi +: 4], bus.req_b[4*gi +: 4], bus.req_op[3*gi +: 3]};
      end
   endgenerate

   assign any_valid    = |bus.req_valid;
   assign arb_en       = (state_reg == ST_ON) && !reset;
   assign idle_expired = (idle_reg == IDLE_W'(IDLE_TIMEOUT));
   assign wake_done    = (wake_reg == WAKE_W'(WAKE_CYCLES - 1));

   rr_arbiter #(.N_REQ(N_REQ)) u_arb (
      .clk         (clk),
      .reset       (reset),
      .en          (arb_en),
      .req         (bus.req_valid),
      .grant       (grant),
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid)
   );

   // A pending request always wins over the timeout, so ISO never sees an op in flight.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_ON:      if (idle_expired && !any_valid && !inflight_reg) state_next = ST_ISO;
         ST_ISO:     state_next = ST_OFF;
         ST_OFF:     if (any_valid) state_next = ST_WAKE;
         ST_WAKE:    if (wake_done) state_next = ST_RESTORE;
         ST_RESTORE: state_next = ST_ON;
         default:    state_next = ST_ON;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg       <= ST_ON;
         idle_reg        <= '0;
         wake_reg        <= '0;
         inflight_reg    <= 1'b0;
         inflight_id_reg <= '0;
         cmd_reg         <= '0;
         rsp_valid_reg   <= 1'b0;
         rsp_id_reg      <= '0;
         rsp_result_reg  <= '0;
      end else begin
         state_reg    <= state_next;
         inflight_reg <= grant_valid;
         if (grant_valid) begin
            cmd_reg         <= req_cmd[grant_idx];
            inflight_id_reg <= grant_idx;
         end

         rsp_valid_reg <= inflight_reg;
         if (inflight_reg) begin
            rsp_result_reg <= bus.alu_result;
            rsp_id_reg     <= inflight_id_reg;
         end

         if (state_reg != ST_ON || any_valid || inflight_reg) begin
            idle_reg <= '0;
         end else if (!idle_expired) begin
            idle_reg <= idle_reg + 1'b1;
         end

         if (state_reg == ST_WAKE && state_next == ST_WAKE) begin
            wake_reg <= wake_reg + 1'b1;
         end else begin
            wake_reg <= '0;
         end
      end
   end

   assign bus.req_ready  = grant;
   assign bus.alu_a      = cmd_reg.a;
   assign bus.alu_b      = cmd_reg.b;
   assign bus.alu_op     = cmd_reg.op;
   assign bus.rsp_valid  = rsp_valid_reg;
   assign bus.rsp_id     = rsp_id_reg;
   assign bus.rsp_result = rsp_result_reg;

   assign pwr_en    = (state_reg != ST_OFF);
   assign iso_en    = (state_reg != ST_ON);
   assign save      = (state_reg == ST_ISO);
   assign restore   = (state_reg == ST_RESTORE);
   assign pwr_state = state_reg;

endmodule

// File: tb/tb_alu_power_scheduler.sv
// Self-checking bench: directed vector table, power-sequence scenarios and random traffic vs a reference model.
module tb_alu_power_scheduler;
   import alu_power_scheduler_pkg::*;

   localparam int N  = 4;
   localparam int TO = 8;
   localparam int WC = 3;

   logic       clk = 1'b0;
   logic       reset;
   logic       pwr_en, iso_en, save, restore;
   logic [2:0] pwr_state;

   always #5 clk = ~clk;

   alu_power_scheduler_if #(.N_REQ(N)) bus ();

   alu_power_scheduler #(.N_REQ(N), .IDLE_TIMEOUT(TO), .WAKE_CYCLES(WC)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .pwr_en    (pwr_en),
      .iso_en    (iso_en),
      .save      (save),
      .restore   (restore),
      .pwr_state (pwr_state)
   );

   function automatic logic [3:0] alu_fn(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
      case (op)
         OP_ADD:  return a + b;
         OP_SUB:  return a - b;
         OP_AND:  return a & b;
         OP_OR:   return a | b;
         OP_XOR:  return a ^ b;
         OP_NOT:  return ~a;
         OP_SHL:  return a << 1;
         default: return a >> 1;
      endcase
   endfunction

   // External ALU is part of the environment.
   assign bus.alu_result = alu_fn(bus.alu_a, bus.alu_b, bus.alu_op);

   int n_cmp  = 0;
   int n_fail = 0;
   int cyc    = 0;

   task automatic chk(input string name, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %0d, expected %0d", name, cyc, got, exp);
      end
   endtask

   // Reference model: power phase, length of the current quiet run, time spent waking,
   // and a one-deep pipeline of accepted operations.
   pwr_state_e m_state;
   int         m_quiet, m_wake, m_ptr;
   bit         m_infl, m_rsp_v;
   int         m_infl_id, m_rsp_id;
   logic [3:0] m_infl_res, m_rsp_res, m_alu_a, m_alu_b;
   logic [2:0] m_alu_op;

   task automatic m_reset();
      m_state = PS_ON; m_quiet = 0; m_wake = 0; m_ptr = 0;
      m_infl = 0; m_rsp_v = 0; m_infl_id = 0; m_rsp_id = 0;
      m_infl_res = 0; m_rsp_res = 0; m_alu_a = 0; m_alu_b = 0; m_alu_op = 0;
   endtask

   function automatic int m_winner(input logic [3:0] v);
      if (m_state != PS_ON || reset) return -1;
      for (int k = 0; k < N; k++) begin
         if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
      end
      return -1;
   endfunction

   task automatic m_step(input logic [3:0] v, input logic [15:0] a, input logic [15:0] b, input logic [11:0] op);
      int g;
      bit quiet;
      g = m_winner(v);
      quiet = (v == 0) && !m_infl;
      m_rsp_v = m_infl;
      if (m_infl) begin
         m_rsp_id  = m_infl_id;
         m_rsp_res = m_infl_res;
      end
      m_infl = (g >= 0);
      if (g >= 0) begin
         m_alu_a    = a[4*g +: 4];
         m_alu_b    = b[4*g +: 4];
         m_alu_op   = op[3*g +: 3];
         m_infl_id  = g;
         m_infl_res = alu_fn(m_alu_a, m_alu_b, m_alu_op);
         m_ptr      = (g + 1) % N;
      end
      case (m_state)
         PS_ON: begin
            m_quiet = quiet ? m_quiet + 1 : 0;
            // Power-down happens at the end of the (TO+1)-th consecutive quiet cycle.
            if (m_quiet == TO + 1) begin
               m_state = PS_ISO;
               m_quiet = 0;
            end
         end
         PS_ISO: m_state = PS_OFF;
         PS_OFF: if (v != 0) begin
            m_state = PS_WAKE;
            m_wake  = 0;
         end
         PS_WAKE: begin
            m_wake++;
            if (m_wake == WC) m_state = PS_RESTORE;
         end
         default: begin
            m_state = PS_ON;
            m_quiet = 0;
         end
      endcase
   endtask

   task automatic check_model(input logic [3:0] v);
      int g;
      g = m_winner(v);
      chk("req_ready", int'(bus.req_ready), (g < 0) ? 0 : (1 << g));
      chk("pwr_state", int'(pwr_state), int'(m_state));
      chk("pwr_en", int'(pwr_en), int'(m_state != PS_OFF));
      chk("iso_en", int'(iso_en), int'(m_state != PS_ON));
      chk("save", int'(save), int'(m_state == PS_ISO));
      chk("restore", int'(restore), int'(m_state == PS_RESTORE));
      chk("rsp_valid", int'(bus.rsp_valid), int'(m_rsp_v));
      if (m_rsp_v || reset) begin
         chk("rsp_id", int'(bus.rsp_id), m_rsp_id);
         chk("rsp_result", int'(bus.rsp_result), int'(m_rsp_res));
      end
      chk("alu_a", int'(bus.alu_a), int'(m_alu_a));
      chk("alu_b", int'(bus.alu_b), int'(m_alu_b));
      chk("alu_op", int'(bus.alu_op), int'(m_alu_op));
   endtask

   task automatic drive_and_check(input logic rst, input logic [3:0] v, input logic [15:0] a,
                                  input logic [15:0] b, input logic [11:0] op);
      @(negedge clk);
      reset         = rst;
      bus.req_valid = v;
      bus.req_a     = a;
      bus.req_b     = b;
      bus.req_op    = op;
      if (rst) m_reset();
      #1;
      check_model(v);
   endtask

   task automatic finish_cycle(input logic rst, input logic [3:0] v, input logic [15:0] a,
                               input logic [15:0] b, input logic [11:0] op);
      @(posedge clk);
      if (rst) m_reset();
      else m_step(v, a, b, op);
      cyc++;
   endtask

   task automatic cycle(input logic rst, input logic [3:0] v, input logic [15:0] a,
                        input logic [15:0] b, input logic [11:0] op);
      drive_and_check(rst, v, a, b, op);
      finish_cycle(rst, v, a, b, op);
   endtask

   typedef struct {
      logic        rst;
      logic [3:0]  v;
      logic [15:0] a;
      logic [15:0] b;
      logic [11:0] op;
      logic [3:0]  e_ready;
      logic [2:0]  e_state;
      logic        e_rv;
      logic [1:0]  e_id;
      logic [3:0]  e_res;
   } vec_t;

   vec_t tbl [13];

   initial begin
      logic [3:0] rv;
      int gap;
      bit rr;

      reset = 1'b1;
      bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0; bus.req_op = '0;
      m_reset();

      // Single op 3+4, then all four requesters back-to-back in round-robin order.
      tbl[0]  = '{1'b1, 4'b0001, 16'h0003, 16'h0004, 12'h000, 4'b0000, 3'd0, 1'b0, 2'd0, 4'd0};
      tbl[1]  = '{1'b0, 4'b0001, 16'h0003, 16'h0004, 12'h000, 4'b0001, 3'd0, 1'b0, 2'd0, 4'd0};
      tbl[2]  = '{1'b0, 4'b0000, 16'h0003, 16'h0004, 12'h000, 4'b0000, 3'd0, 1'b0, 2'd0, 4'd0};
      tbl[3]  = '{1'b0, 4'b0000, 16'h0003, 16'h0004, 12'h000, 4'b0000, 3'd0, 1'b1, 2'd0, 4'd7};
      tbl[4]  = '{1'b1, 4'b1111, 16'h4321, 16'h1111, 12'h000, 4'b0000, 3'd0, 1'b0, 2'd0, 4'd0};
      tbl[5]  = '{1'b0, 4'b1111, 16'h4321, 16'h1111, 12'h000, 4'b0001, 3'd0, 1'b0, 2'd0, 4'd0};
      tbl[6]  = '{1'b0, 4'b1111, 16'h4321, 16'h1111, 12'h000, 4'b0010, 3'd0, 1'b0, 2'd0, 4'd0};
      tbl[7]  = '{1'b0, 4'b1111, 16'h4321, 16'h1111, 12'h000, 4'b0100, 3'd0, 1'b1, 2'd0, 4'd2};
      tbl[8]  = '{1'b0, 4'b1111, 16'h4321, 16'h1111, 12'h000, 4'b1000, 3'd0, 1'b1, 2'd1, 4'd3};
      tbl[9]  = '{1'b0, 4'b1111, 16'h4321, 16'h1111, 12'h000, 4'b0001, 3'd0, 1'b1, 2'd2, 4'd4};
      tbl[10] = '{1'b0, 4'b0000, 16'h4321, 16'h1111, 12'h000, 4'b0000, 3'd0, 1'b1, 2'd3, 4'd5};
      tbl[11] = '{1'b0, 4'b0000, 16'h4321, 16'h1111, 12'h000, 4'b0000, 3'd0, 1'b1, 2'd0, 4'd2};
      tbl[12] = '{1'b0, 4'b0000, 16'h4321, 16'h1111, 12'h000, 4'b0000, 3'd0, 1'b0, 2'd0, 4'd0};

      for (int i = 0; i < 13; i++) begin
         drive_and_check(tbl[i].rst, tbl[i].v, tbl[i].a, tbl[i].b, tbl[i].op);
         chk("tbl_ready", int'(bus.req_ready), int'(tbl[i].e_ready));
         chk("tbl_state", int'(pwr_state), int'(tbl[i].e_state));
         chk("tbl_rsp_valid", int'(bus.rsp_valid), int'(tbl[i].e_rv));
         if (tbl[i].e_rv) begin
            chk("tbl_rsp_id", int'(bus.rsp_id), int'(tbl[i].e_id));
            chk("tbl_rsp_result", int'(bus.rsp_result), int'(tbl[i].e_res));
         end
         finish_cycle(tbl[i].rst, tbl[i].v, tbl[i].a, tbl[i].b, tbl[i].op);
         $display("vec %0d: ready=%b state=%0d rsp_valid=%0d id=%0d result=%0d",
                  i, bus.req_ready, pwr_state, bus.rsp_valid, bus.rsp_id, bus.rsp_result);
      end

      // Quiet run continues: ISO with save, then OFF.
      for (int i = 0; i < 7; i++) cycle(1'b0, 4'b0000, 16'h0, 16'h0, 12'h0);
      drive_and_check(1'b0, 4'b0000, 16'h0, 16'h0, 12'h0);
      chk("seq_iso_state", int'(pwr_state), 1);
      chk("seq_iso_save", int'(save), 1);
      finish_cycle(1'b0, 4'b0000, 16'h0, 16'h0, 12'h0);
      drive_and_check(1'b0, 4'b0000, 16'h0, 16'h0, 12'h0);
      chk("seq_off_state", int'(pwr_state), 2);
      chk("seq_off_pwr_en", int'(pwr_en), 0);
      chk("seq_off_iso_en", int'(iso_en), 1);
      chk("seq_off_save", int'(save), 0);
      finish_cycle(1'b0, 4'b0000, 16'h0, 16'h0, 12'h0);
      $display("seq power-down: state=%0d pwr_en=%0d iso_en=%0d", pwr_state, pwr_en, iso_en);

      // Wake from OFF by requester 2: 9-1.
      for (int i = 0; i < 6; i++) begin
         drive_and_check(1'b0, 4'b0100, 16'h0900, 16'h0100, 12'h040);
         if (i == 0) chk("seq_wake_off", int'(pwr_state), 2);
         if (i >= 1 && i <= 3) chk("seq_wake_state", int'(pwr_state), 3);
         if (i == 4) chk("seq_restore_pulse", int'(restore), 1);
         if (i == 5) chk("seq_wake_ready", int'(bus.req_ready), 4'b0100);
         finish_cycle(1'b0, 4'b0100, 16'h0900, 16'h0100, 12'h040);
      end
      cycle(1'b0, 4'b0000, 16'h0, 16'h0, 12'h0);
      drive_and_check(1'b0, 4'b0000, 16'h0, 16'h0, 12'h0);
      chk("seq_wake_rsp_valid", int'(bus.rsp_valid), 1);
      chk("seq_wake_rsp_id", int'(bus.rsp_id), 2);
      chk("seq_wake_rsp_result", int'(bus.rsp_result), 8);
      finish_cycle(1'b0, 4'b0000, 16'h0, 16'h0, 12'h0);
      $display("seq wake: rsp_id=%0d rsp_result=%0d", bus.rsp_id, bus.rsp_result);

      // Request raised during ISO: one OFF cycle, then full wake, then served (5 & 6).
      for (int i = 0; i < 8; i++) cycle(1'b0, 4'b0000, 16'h0, 16'h0, 12'h0);
      for (int i = 0; i < 7; i++) begin
         drive_and_check(1'b0, 4'b0001, 16'h0005, 16'h0006, 12'h002);
         if (i == 0) chk("seq_isoreq_iso", int'(pwr_state), 1);
         if (i == 1) chk("seq_isoreq_off", int'(pwr_state), 2);
         if (i == 2) chk("seq_isoreq_wake", int'(pwr_state), 3);
         if (i == 6) chk("seq_isoreq_ready", int'(bus.req_ready), 4'b0001);
         finish_cycle(1'b0, 4'b0001, 16'h0005, 16'h0006, 12'h002);
      end
      cycle(1'b0, 4'b0000, 16'h0, 16'h0, 12'h0);
      drive_and_check(1'b0, 4'b0000, 16'h0, 16'h0, 12'h0);
      chk("seq_isoreq_rsp_id", int'(bus.rsp_id), 0);
      chk("seq_isoreq_rsp_result", int'(bus.rsp_result), 4);
      finish_cycle(1'b0, 4'b0000, 16'h0, 16'h0, 12'h0);
      $display("seq iso-request: rsp_id=%0d rsp_result=%0d", bus.rsp_id, bus.rsp_result);

      // Reset pulsed during WAKE.
      for (int k = 0; k < 40 && m_state != PS_OFF; k++) cycle(1'b0, 4'b0000, 16'h0, 16'h0, 12'h0);
      drive_and_check(1'b0, 4'b0010, 16'h0, 16'h0, 12'h0);
      chk("seq_rst_reach_off", int'(pwr_state), 2);
      finish_cycle(1'b0, 4'b0010, 16'h0, 16'h0, 12'h0);
      cycle(1'b0, 4'b0010, 16'h0, 16'h0, 12'h0);
      for (int i = 0; i < 2; i++) begin
         drive_and_check(1'b1, 4'b0010, 16'h0, 16'h0, 12'h0);
         chk("seq_rst_state", int'(pwr_state), 0);
         chk("seq_rst_pwr_en", int'(pwr_en), 1);
         chk("seq_rst_iso_en", int'(iso_en), 0);
         chk("seq_rst_ready", int'(bus.req_ready), 0);
         finish_cycle(1'b1, 4'b0010, 16'h0, 16'h0, 12'h0);
      end
      for (int i = 0; i < 3; i++) begin
         drive_and_check(1'b0, 4'b0000, 16'h0, 16'h0, 12'h0);
         chk("seq_rst_no_rsp", int'(bus.rsp_valid), 0);
         finish_cycle(1'b0, 4'b0000, 16'h0, 16'h0, 12'h0);
      end
      $display("seq reset-in-wake: state=%0d rsp_valid=%0d", pwr_state, bus.rsp_valid);

      // Random traffic with idle gaps long enough to exercise power cycling.
      gap = 0;
      for (int i = 0; i < 2500; i++) begin
         if (gap > 0) begin
            rv = 4'b0000;
            gap--;
         end else begin
            rv = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) gap = $urandom_range(5, 25);
         end
         rr = ($urandom_range(0, 299) == 0);
         cycle(rr, rv, 16'($urandom), 16'($urandom), 12'($urandom));
      end
      $display("random phase: %0d cycles, %0d compares so far", cyc, n_cmp);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
